data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_array.sv | 47 ++++
 rtl/data_mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data memory controller:
//               controller state encoding, data word width, default latency
//               and the width of the latency down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int WORD_W          = 32;
  localparam int DEFAULT_LATENCY = 2;
  // Wide enough to hold LATENCY-1 for the whole legal range 1..15.
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Synchronous single-port word RAM. Writes land on the clock
//               edge when we is high. The read register loads only when re
//               is high and otherwise holds its last value, so it can act
//               directly as the processor-facing read data register.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
  end

  // Read register: cleared by reset, loaded only on a completed read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[idx];
    end
  end

  assign rdata = r_rdata;

endmodule : dmem_array
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Fixed-latency data memory controller. Captures one read or
//               write request from the processor, waits LATENCY cycles, then
//               completes it with a one-cycle mem_ready pulse. Read and write
//               both asserted is answered with mem_error and no array access.
//               Optional macro DMEM_ADDR_CHECK_EN: misaligned or out-of-range
//               addresses also produce mem_error; without it the address
//               wraps modulo DEPTH_WORDS and the byte offset is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              pc_reset,
  input  logic [WORD_W-1:0] data_addr,
  input  logic [WORD_W-1:0] data_in,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [WORD_W-1:0] data_out,
  output logic              mem_ready,
  output logic              mem_error
);

  localparam int             IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LATENCY - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_to_resp;

  logic [IDX_W-1:0]    r_idx;
  logic [WORD_W-1:0]   r_wdata;
  logic                r_rd;
  logic                r_wr;
  logic                r_err;

  logic                w_req;
  logic                w_cap;
  logic                w_addr_err;
  logic                w_live_err;
  logic [IDX_W-1:0]    w_live_idx;

  logic [IDX_W-1:0]    w_idx;
  logic [WORD_W-1:0]   w_wdata;
  logic                w_rd;
  logic                w_wr;
  logic                w_err;
  logic                w_we;
  logic                w_re;

  assign w_req      = mem_read | mem_write;
  assign w_cap      = (r_state == IDLE) && w_req;
  assign w_live_idx = data_addr[IDX_W+1:2];

`ifdef DMEM_ADDR_CHECK_EN
  assign w_addr_err = (data_addr[1:0] != 2'b00) || (data_addr[WORD_W-1:IDX_W+2] != '0);
`else
  assign w_addr_err = 1'b0;
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, data_addr[1:0], data_addr[WORD_W-1:IDX_W+2]};
`endif

  assign w_live_err = (mem_read & mem_write) | w_addr_err;

  // With LATENCY=1 the controller goes from IDLE straight to RESP on the
  // capture edge, so the array must see the live request in IDLE and the
  // captured request in BUSY.
  assign w_idx   = (r_state == IDLE) ? w_live_idx : r_idx;
  assign w_wdata = (r_state == IDLE) ? data_in    : r_wdata;
  assign w_rd    = (r_state == IDLE) ? mem_read   : r_rd;
  assign w_wr    = (r_state == IDLE) ? mem_write  : r_wr;
  assign w_err   = (r_state == IDLE) ? w_live_err : r_err;

  // Array access happens only on the edge that enters RESP.
  assign w_we = w_to_resp & w_wr & ~w_err;
  assign w_re = w_to_resp & w_rd & ~w_err;

  // State and latency counter register.
  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: capture in IDLE, count down in BUSY, single-cycle RESP.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_to_resp   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_cnt_nxt = c_cnt_load;
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
            w_to_resp   = 1'b1;
          end else begin
            w_state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
          w_to_resp   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request capture; held unchanged until the next request is accepted.
  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      r_idx   <= '0;
      r_wdata <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_cap) begin
      r_idx   <= w_live_idx;
      r_wdata <= data_in;
      r_rd    <= mem_read;
      r_wr    <= mem_write;
      r_err   <= w_live_err;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (pc_reset),
    .we    (w_we),
    .re    (w_re),
    .idx   (w_idx),
    .wdata (w_wdata),
    .rdata (data_out)
  );

  assign mem_ready = (r_state == RESP);
  assign mem_error = (r_state == RESP) & r_err;

endmodule : data_mem_ctrl
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Self-checking bench for data_mem_ctrl. Instance a uses
//               LATENCY=2, instance b uses LATENCY=1 for back-to-back reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

`ifdef DMEM_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        pc_reset;

  logic [31:0] a_addr = '0, a_wdata = '0, a_dout;
  logic        a_read = 1'b0, a_write = 1'b0, a_ready, a_error;
  logic [31:0] b_addr = '0, b_wdata = '0, b_dout;
  logic        b_read = 1'b0, b_write = 1'b0, b_ready, b_error;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t        a_q[$];
  exp_t        b_q[$];
  logic [31:0] a_model [256];
  logic [31:0] b_model [256];
  logic [31:0] a_last_rd = '0;
  logic [31:0] b_last_rd = '0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
    .clk       (clk),
    .pc_reset  (pc_reset),
    .data_addr (a_addr),
    .data_in   (a_wdata),
    .mem_read  (a_read),
    .mem_write (a_write),
    .data_out  (a_dout),
    .mem_ready (a_ready),
    .mem_error (a_error)
  );

  data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(1)) dut_b (
    .clk       (clk),
    .pc_reset  (pc_reset),
    .data_addr (b_addr),
    .data_in   (b_wdata),
    .mem_read  (b_read),
    .mem_write (b_write),
    .data_out  (b_dout),
    .mem_ready (b_ready),
    .mem_error (b_error)
  );

  // Compute expected response from the bench model and push it.
  function automatic exp_t model_req(input logic rd, input logic wr, input logic [31:0] addr,
                                     input logic [31:0] wd, input bit use_b);
    exp_t e;
    int   idx;
    idx   = int'(addr[9:2]);
    e.err = (rd & wr) | (ADDR_CHECK & ((addr[1:0] != 2'b00) | (addr[31:10] != 22'd0)));
    if (use_b) begin
      if (!e.err && wr) b_model[idx] = wd;
      if (!e.err && rd) b_last_rd = b_model[idx];
      e.data = b_last_rd;
    end else begin
      if (!e.err && wr) a_model[idx] = wd;
      if (!e.err && rd) a_last_rd = a_model[idx];
      e.data = a_last_rd;
    end
    return e;
  endfunction

  // One request on instance a: latency, data, error and pulse width checks.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input string name);
    int   waited;
    bit   seen;
    exp_t e;
    @(posedge clk); #1;
    a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd;
    a_q.push_back(model_req(rd, wr, addr, wd, 1'b0));
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 20) begin
      @(negedge clk);
      waited++;
      if (a_ready === 1'b1) seen = 1'b1;
    end
    a_read = 1'b0; a_write = 1'b0;
    n_checks++;
    if (!seen) begin
      $display("FAIL %s ready_timeout: mem_ready never rose within %0d cycles", name, waited);
      void'(a_q.pop_front());
    end else begin
      n_pass++;
      e = a_q.pop_front();
      n_checks++;
      if (waited !== 4) $display("FAIL %s latency: got %0d negedges, expected 4", name, waited);
      else n_pass++;
      n_checks++;
      if (a_error !== e.err) $display("FAIL %s mem_error: got %b expected %b", name, a_error, e.err);
      else n_pass++;
      n_checks++;
      if (a_dout !== e.data) $display("FAIL %s data_out: got %h expected %h", name, a_dout, e.data);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (a_ready !== 1'b0) $display("FAIL %s ready_pulse: got %b expected 0", name, a_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    pc_reset = 1'b1;
    #2;
    n_checks++;
    if (a_ready !== 1'b0) $display("FAIL reset_ready_a: got %b expected 0", a_ready); else n_pass++;
    n_checks++;
    if (a_error !== 1'b0) $display("FAIL reset_error_a: got %b expected 0", a_error); else n_pass++;
    n_checks++;
    if (a_dout !== 32'h0) $display("FAIL reset_dout_a: got %h expected 0", a_dout); else n_pass++;
    n_checks++;
    if (b_ready !== 1'b0) $display("FAIL reset_ready_b: got %b expected 0", b_ready); else n_pass++;
    n_checks++;
    if (b_dout !== 32'h0) $display("FAIL reset_dout_b: got %h expected 0", b_dout); else n_pass++;
    repeat (2) @(negedge clk);
    pc_reset = 1'b0;
  endtask

  task automatic test_write_read();
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr_0x10");
    do_req(1'b1, 1'b0, 32'h10, 32'h0,        "rd_0x10");
  endtask

  task automatic test_pair();
    do_req(1'b0, 1'b1, 32'h0, 32'h1, "wr_0x0");
    do_req(1'b0, 1'b1, 32'h4, 32'h2, "wr_0x4");
    do_req(1'b1, 1'b0, 32'h0, 32'h0, "rd_0x0");
    do_req(1'b1, 1'b0, 32'h4, 32'h0, "rd_0x4");
  endtask

  task automatic test_conflict();
    do_req(1'b0, 1'b1, 32'h8, 32'h12345678, "wr_0x8");
    do_req(1'b1, 1'b0, 32'h4, 32'h0,        "rd_0x4_pre");
    do_req(1'b1, 1'b1, 32'h8, 32'hFFFFFFFF, "both_0x8");
    do_req(1'b1, 1'b0, 32'h8, 32'h0,        "rd_0x8_post");
  endtask

  task automatic test_addr_check();
    do_req(1'b0, 1'b1, 32'h3,   32'hAAAA0003, "wr_0x3");
    do_req(1'b1, 1'b0, 32'h0,   32'h0,        "rd_0x0_after_0x3");
    do_req(1'b1, 1'b0, 32'h410, 32'h0,        "rd_0x410");
  endtask

  task automatic test_reset_abort();
    do_req(1'b0, 1'b1, 32'h20, 32'h11111111, "wr_0x20_old");
    do_req(1'b1, 1'b0, 32'h10, 32'h0,        "rd_0x10_nonzero");
    @(posedge clk); #1;
    a_write = 1'b1; a_addr = 32'h20; a_wdata = 32'h55;
    @(posedge clk);
    #3;
    pc_reset = 1'b1;
    #1;
    a_write = 1'b0;
    n_checks++;
    if (a_dout !== 32'h0) $display("FAIL abort_dout: got %h expected 0", a_dout); else n_pass++;
    n_checks++;
    if (a_ready !== 1'b0) $display("FAIL abort_ready: got %b expected 0", a_ready); else n_pass++;
    n_checks++;
    if (a_error !== 1'b0) $display("FAIL abort_error: got %b expected 0", a_error); else n_pass++;
    a_last_rd = 32'h0;
    b_last_rd = 32'h0;
    repeat (2) @(negedge clk);
    pc_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (a_ready !== 1'b0) $display("FAIL abort_no_ready[%0d]: got %b expected 0", i, a_ready);
      else n_pass++;
    end
    do_req(1'b1, 1'b0, 32'h20, 32'h0, "rd_0x20_retained");
  endtask

  task automatic test_back_to_back();
    logic        op_rd [6];
    logic        op_wr [6];
    logic [31:0] op_ad [6];
    logic [31:0] op_wd [6];
    int          k, waited, prev;
    exp_t        e;
    op_rd = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    op_wr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    op_ad = '{32'h40, 32'h44, 32'h40, 32'h44, 32'h44, 32'h40};
    op_wd = '{32'hCAFE0040, 32'hBEEF0044, 32'h0, 32'h0, 32'h0, 32'h0};
    @(posedge clk); #1;
    b_read = op_rd[0]; b_write = op_wr[0]; b_addr = op_ad[0]; b_wdata = op_wd[0];
    b_q.push_back(model_req(op_rd[0], op_wr[0], op_ad[0], op_wd[0], 1'b1));
    k = 0; waited = 0; prev = 0;
    while (k < 6 && waited < 40) begin
      @(negedge clk);
      waited++;
      if (b_ready === 1'b1) begin
        e = b_q.pop_front();
        n_checks++;
        if ((waited - prev) !== 2)
          $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 2", k, waited - prev);
        else n_pass++;
        n_checks++;
        if (b_dout !== e.data) $display("FAIL b2b_data[%0d]: got %h expected %h", k, b_dout, e.data);
        else n_pass++;
        n_checks++;
        if (b_error !== e.err) $display("FAIL b2b_error[%0d]: got %b expected %b", k, b_error, e.err);
        else n_pass++;
        prev = waited;
        k++;
        if (k < 6) begin
          b_read = op_rd[k]; b_write = op_wr[k]; b_addr = op_ad[k]; b_wdata = op_wd[k];
          b_q.push_back(model_req(op_rd[k], op_wr[k], op_ad[k], op_wd[k], 1'b1));
        end else begin
          b_read = 1'b0; b_write = 1'b0;
        end
      end
    end
    b_read = 1'b0; b_write = 1'b0;
    n_checks++;
    if (k !== 6) $display("FAIL b2b_timeout: got %0d completions expected 6", k);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_pair();
    test_conflict();
    test_addr_check();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule : tb_data_mem_ctrl
`default_nettype wire
